// File: rtl/ram_block_dp_clr.sv
// Purpose : simple dual-port byte-writable RAM with a whole-memory clear engine
//           (clear on request and, optionally, automatically after reset).
// Latency : read data and rd_valid appear RD_LAT cycles after the read is taken.
// Backpres: no flow control; while busy=1 (clearing) wr_en, rd_en and clr_req are dropped.
//
// Ports:
//   clk, resetn            single rising-edge clock, async active-low reset
//   wr_en/wr_addr/wr_be/wr_data   write port, byte enables per 8-bit lane
//   rd_en/rd_addr          read request
//   rd_data/rd_valid       registered read data, one-cycle valid pulse
//   clr_req                start zeroing the whole memory
//   busy                   high for exactly DEPTH cycles while the clear runs

module ram_block_dp_clr #(
    parameter  int WIDTH      = 32,
    parameter  int DEPTH      = 1024,
    parameter  int RD_LAT     = 1,
    parameter  int WR_MODE    = 0,
    parameter  int CLR_ON_RST = 1,
    localparam int AWIDTH     = $clog2(DEPTH),
    localparam int BEW        = WIDTH / 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [BEW-1:0]    wr_be,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              clr_req,
    output logic              busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam state_t            RST_STATE = (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
    // One extra bit so the range check is a real compare even when DEPTH is a power of 2.
    localparam logic [AWIDTH:0]   DEPTH_EXT = (AWIDTH + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_nxt;
    logic [AWIDTH-1:0] clr_cnt;
    logic [AWIDTH-1:0] clr_cnt_nxt;
    logic              clr_we;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= RST_STATE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        case (state)
            S_IDLE: begin
                if (clr_req) begin
                    state_nxt   = S_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            S_CLEAR: begin
                // clr_req is deliberately not looked at here: no restart mid-clear.
                clr_we      = 1'b1;
                clr_cnt_nxt = clr_cnt + AWIDTH'(1);
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt   = S_IDLE;
                    clr_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The state register bit itself is busy; nothing combinational from clr_req.
    assign busy = (state == S_CLEAR);

    // ------------------------------------------------------------------
    // User request qualification
    // ------------------------------------------------------------------
    logic wr_in_range;
    logic rd_in_range;
    logic wr_ok;
    logic rd_fire;
    logic collide;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    assign wr_ok       = wr_en & ~busy & wr_in_range;
    assign rd_fire     = rd_en & ~busy;
    assign collide     = wr_ok & rd_in_range & (wr_addr == rd_addr);

    // ------------------------------------------------------------------
    // Storage: one write port shared by the clear engine and the user.
    // The two never overlap because user writes are blocked while clearing.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [BEW-1:0]    mem_be;
    logic [WIDTH-1:0]  mem_wdat;

    // resetn gates the port so no clear write lands while reset is still held;
    // the first clear write is then the first edge after release.
    assign mem_we   = resetn & (clr_we | wr_ok);
    assign mem_addr = clr_we ? clr_cnt : wr_addr;
    assign mem_be   = clr_we ? {BEW{1'b1}} : wr_be;
    assign mem_wdat = clr_we ? '0 : wr_data;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BEW; b++) begin
                if (mem_be[b]) begin
                    mem[mem_addr][8*b +: 8] <= mem_wdat[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read word selection. Reading the array before the edge gives the old
    // word (read-first) for free; write-first splices in the enabled bytes.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rd_old;
    logic [WIDTH-1:0] rd_merge;
    logic [WIDTH-1:0] rd_word;

    always_comb begin
        rd_old   = '0;
        rd_merge = '0;
        rd_word  = '0;
        if (rd_in_range) begin
            rd_old = mem[rd_addr];
        end
        rd_merge = rd_old;
        for (int b = 0; b < BEW; b++) begin
            if (wr_be[b]) begin
                rd_merge[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
        rd_word = ((WR_MODE != 0) && collide) ? rd_merge : rd_old;
    end

    // ------------------------------------------------------------------
    // Read pipeline. Data is captured from the array at the issuing edge, so
    // a read taken just before a clear still returns pre-clear contents.
    // rd_data only moves on a valid beat and otherwise holds.
    // ------------------------------------------------------------------
    if (RD_LAT == 1) begin : g_lat1
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                rd_valid <= 1'b0;
                rd_data  <= '0;
            end else begin
                rd_valid <= rd_fire;
                if (rd_fire) begin
                    rd_data <= rd_word;
                end
            end
        end
    end else begin : g_lat2
        logic             p1_vld;
        logic [WIDTH-1:0] p1_dat;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                p1_vld   <= 1'b0;
                p1_dat   <= '0;
                rd_valid <= 1'b0;
                rd_data  <= '0;
            end else begin
                p1_vld <= rd_fire;
                if (rd_fire) begin
                    p1_dat <= rd_word;
                end
                rd_valid <= p1_vld;
                if (p1_vld) begin
                    rd_data <= p1_dat;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_block_dp_clr.sv
// Purpose : directed checks of ram_block_dp_clr in two configurations
//           (u0: DEPTH 1024, RD_LAT 1, read-first; u1: DEPTH 1000, RD_LAT 2, write-first).
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpres: none; every wait on busy is bounded.

module tb_ram_block_dp_clr;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn  [2];
    logic        wr_en   [2];
    logic [9:0]  wr_addr [2];
    logic [3:0]  wr_be   [2];
    logic [31:0] wr_data [2];
    logic        rd_en   [2];
    logic [9:0]  rd_addr [2];
    logic [31:0] rd_data [2];
    logic        rd_valid[2];
    logic        clr_req [2];
    logic        busy    [2];

    ram_block_dp_clr #(
        .WIDTH(32), .DEPTH(1024), .RD_LAT(1), .WR_MODE(0), .CLR_ON_RST(1)
    ) u0 (
        .clk(clk), .resetn(resetn[0]),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_be(wr_be[0]), .wr_data(wr_data[0]),
        .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
        .clr_req(clr_req[0]), .busy(busy[0])
    );

    ram_block_dp_clr #(
        .WIDTH(32), .DEPTH(1000), .RD_LAT(2), .WR_MODE(1), .CLR_ON_RST(1)
    ) u1 (
        .clk(clk), .resetn(resetn[1]),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_be(wr_be[1]), .wr_data(wr_data[1]),
        .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
        .clr_req(clr_req[1]), .busy(busy[1])
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int depth_of(input int d);
        return (d == 0) ? 1024 : 1000;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs(input int d);
        wr_en[d]   = 1'b0;
        wr_addr[d] = '0;
        wr_be[d]   = '0;
        wr_data[d] = '0;
        rd_en[d]   = 1'b0;
        rd_addr[d] = '0;
        clr_req[d] = 1'b0;
    endtask

    task automatic wr(input int d, input int addr, input logic [3:0] be, input logic [31:0] dat);
        wr_en[d]   = 1'b1;
        wr_addr[d] = 10'(addr);
        wr_be[d]   = be;
        wr_data[d] = dat;
        tick();
        wr_en[d]   = 1'b0;
    endtask

    task automatic rd_chk(input int d, input int addr, input logic [31:0] exp, input string tag);
        rd_en[d]   = 1'b1;
        rd_addr[d] = 10'(addr);
        tick();
        rd_en[d]   = 1'b0;
        repeat (lat_of(d) - 1) tick();
        check({tag, "_vld"}, 32'(rd_valid[d]), 32'd1);
        check(tag, rd_data[d], exp);
    endtask

    // Same-cycle write and read of one address.
    task automatic collide(input int d, input int addr, input logic [3:0] be,
                           input logic [31:0] dat, input logic [31:0] exp, input string tag);
        wr_en[d]   = 1'b1;
        wr_addr[d] = 10'(addr);
        wr_be[d]   = be;
        wr_data[d] = dat;
        rd_en[d]   = 1'b1;
        rd_addr[d] = 10'(addr);
        tick();
        wr_en[d]   = 1'b0;
        rd_en[d]   = 1'b0;
        repeat (lat_of(d) - 1) tick();
        check({tag, "_vld"}, 32'(rd_valid[d]), 32'd1);
        check(tag, rd_data[d], exp);
    endtask

    // Counts falling edges until busy drops. With junk=1 it hammers writes,
    // reads and clr_req every cycle, all of which must be ignored.
    task automatic busy_count(input int d, input bit junk, output int cnt, output int rv_bad);
        cnt    = 0;
        rv_bad = 0;
        while (busy[d] && cnt < 4000) begin
            if (cnt >= lat_of(d) && rd_valid[d]) rv_bad++;
            if (junk) begin
                wr_en[d]   = 1'b1;
                wr_addr[d] = '0;
                wr_be[d]   = 4'hF;
                wr_data[d] = 32'hFFFF_FFFF;
                rd_en[d]   = 1'b1;
                rd_addr[d] = 10'(cnt);
                clr_req[d] = 1'b1;
            end
            tick();
            cnt++;
        end
        idle_inputs(d);
    endtask

    // Eight back-to-back reads of addresses 0..7 holding 0x100+i.
    task automatic burst(input int d);
        int lat;
        bit exp_v;
        lat = lat_of(d);
        for (int i = 0; i < 8; i++) wr(d, i, 4'hF, 32'(256 + i));
        for (int k = 0; k <= 8 + lat; k++) begin
            exp_v = (k >= lat) && (k < lat + 8);
            check("burst_vld", 32'(rd_valid[d]), 32'(exp_v));
            if (exp_v) check("burst_dat", rd_data[d], 32'(256 + k - lat));
            if (k == 8 + lat) check("burst_hold", rd_data[d], 32'h0000_0107);
            rd_en[d]   = (k < 8);
            rd_addr[d] = 10'(k);
            tick();
        end
        rd_en[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=done");
        $fatal(1);
    end

    initial begin
        int cnt;
        int rv;

        for (int d = 0; d < 2; d++) begin
            resetn[d] = 1'b0;
            idle_inputs(d);
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_busy",  32'(busy[d]),     32'd1);
            check("rst_vld",   32'(rd_valid[d]), 32'd0);
            check("rst_rdata", rd_data[d],       32'd0);
        end

        // ---------------- u0: DEPTH 1024, RD_LAT 1, read-first ----------------
        resetn[0] = 1'b1;
        busy_count(0, 1'b0, cnt, rv);
        check("u0_rst_clr_len", cnt, 32'd1024);

        wr(0, 5, 4'hF, 32'hAABB_CCDD);
        wr(0, 5, 4'b0101, 32'h1122_3344);
        rd_chk(0, 5, 32'hAA22_CC44, "u0_be_merge");
        wr(0, 5, 4'b0000, 32'h0000_0000);
        rd_chk(0, 5, 32'hAA22_CC44, "u0_be_none");

        wr(0, 3, 4'hF, 32'h0);
        wr(0, 4, 4'hF, 32'h0);
        collide(0, 3, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, "u0_col_full");
        rd_chk(0, 3, 32'hFFFF_FFFF, "u0_col_full_mem");
        collide(0, 4, 4'b0011, 32'hFFFF_FFFF, 32'h0000_0000, "u0_col_part");
        rd_chk(0, 4, 32'h0000_FFFF, "u0_col_part_mem");

        burst(0);

        // clr_req with a read in the same cycle, then hammer during the clear
        wr(0, 0,    4'hF, 32'hA0A0_A0A0);
        wr(0, 511,  4'hF, 32'h5A5A_5A5A);
        wr(0, 1023, 4'hF, 32'h1234_5678);
        wr(0, 100,  4'hF, 32'hCAFE_F00D);
        clr_req[0] = 1'b1;
        rd_en[0]   = 1'b1;
        rd_addr[0] = 10'd100;
        tick();
        clr_req[0] = 1'b0;
        rd_en[0]   = 1'b0;
        check("u0_clr_busy", 32'(busy[0]), 32'd1);
        check("u0_clr_rd_vld", 32'(rd_valid[0]), 32'd1);
        check("u0_clr_rd_dat", rd_data[0], 32'hCAFE_F00D);
        busy_count(0, 1'b1, cnt, rv);
        check("u0_gate_len", cnt, 32'd1024);
        check("u0_gate_no_rd", rv, 32'd0);
        rd_chk(0, 0,    32'h0, "u0_gate_a0");
        rd_chk(0, 100,  32'h0, "u0_gate_a100");
        rd_chk(0, 511,  32'h0, "u0_gate_a511");
        rd_chk(0, 1023, 32'h0, "u0_gate_a1023");

        // dirty memory, then a reset pulse must clear it again
        wr(0, 0,    4'hF, 32'hDEAD_0000);
        wr(0, 511,  4'hF, 32'hDEAD_0511);
        wr(0, 1023, 4'hF, 32'hDEAD_1023);
        rd_chk(0, 511, 32'hDEAD_0511, "u0_pre_rst");
        resetn[0] = 1'b0;
        #1;
        check("u0_async_rdata", rd_data[0], 32'd0);
        check("u0_async_busy", 32'(busy[0]), 32'd1);
        tick();
        resetn[0] = 1'b1;
        busy_count(0, 1'b0, cnt, rv);
        check("u0_rst2_clr_len", cnt, 32'd1024);
        rd_chk(0, 0,    32'h0, "u0_rst_a0");
        rd_chk(0, 511,  32'h0, "u0_rst_a511");
        rd_chk(0, 1023, 32'h0, "u0_rst_a1023");

        // ---------------- u1: DEPTH 1000, RD_LAT 2, write-first ----------------
        resetn[1] = 1'b1;
        repeat (300) tick();
        check("u1_mid_busy", 32'(busy[1]), 32'd1);
        resetn[1] = 1'b0;
        #1;
        check("u1_mid_rst_busy", 32'(busy[1]), 32'd1);
        tick();
        resetn[1] = 1'b1;
        busy_count(1, 1'b0, cnt, rv);
        check("u1_restart_len", cnt, 32'(depth_of(1)));

        burst(1);

        wr(1, 3, 4'hF, 32'h0);
        wr(1, 4, 4'hF, 32'h0);
        collide(1, 3, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "u1_col_full");
        rd_chk(1, 3, 32'hFFFF_FFFF, "u1_col_full_mem");
        collide(1, 4, 4'b0011, 32'hFFFF_FFFF, 32'h0000_FFFF, "u1_col_part");
        rd_chk(1, 4, 32'h0000_FFFF, "u1_col_part_mem");

        wr(1, 999,  4'hF, 32'h9999_9999);
        wr(1, 1010, 4'hF, 32'hDEAD_BEEF);
        rd_chk(1, 1010, 32'h0,         "u1_oor_rd");
        rd_chk(1, 999,  32'h9999_9999, "u1_last_word");

        // read taken in the clr_req cycle returns pre-clear data two cycles later
        wr(1, 0, 4'hF, 32'h0BAD_CAFE);
        clr_req[1] = 1'b1;
        rd_en[1]   = 1'b1;
        rd_addr[1] = 10'd0;
        tick();
        clr_req[1] = 1'b0;
        rd_en[1]   = 1'b0;
        check("u1_clr_busy", 32'(busy[1]), 32'd1);
        check("u1_clr_rd_early", 32'(rd_valid[1]), 32'd0);
        tick();
        check("u1_clr_rd_vld", 32'(rd_valid[1]), 32'd1);
        check("u1_clr_rd_dat", rd_data[1], 32'h0BAD_CAFE);
        busy_count(1, 1'b0, cnt, rv);
        check("u1_clr_len", cnt + 1, 32'(depth_of(1)));
        rd_chk(1, 0,   32'h0, "u1_clr_a0");
        rd_chk(1, 999, 32'h0, "u1_clr_a999");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
